// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Sequences the MEM stage against a variable-latency data memory using a
//   one-outstanding-request req/ack handshake. While an access is pending the
//   upstream pipeline is frozen (o_stall) and MEM/WB is fed bubbles. Accesses
//   that see no ack within TIMEOUT wait cycles are aborted, return zero data
//   and raise a sticky error flag.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_MEMRead_M       load request from EX/MEM
//   i_MEMWrite_M      store request from EX/MEM (wins if both are set)
//   i_ALU_out         access address
//   i_Data_Write      store data
//   i_mem_ack         one-cycle completion strobe from memory
//   i_mem_rdata       read data, valid with i_mem_ack
//   i_err_clr         clears o_timeout_err
//   o_mem_req         registered request to memory
//   o_mem_we          registered direction, 1 = write
//   o_mem_addr        registered address
//   o_mem_wdata       registered write data
//   o_Read_Data       load result presented to MEM/WB
//   o_stall           combinational freeze for PC, IF/ID, ID/EX, EX/MEM
//   o_bubble          MEM/WB loads a NOP (same timing as o_stall)
//   o_timeout_err     sticky timeout flag
module mem_stage_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_MEMRead_M,
    input  logic              i_MEMWrite_M,
    input  logic [DATA_W-1:0] i_ALU_out,
    input  logic [DATA_W-1:0] i_Data_Write,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_err_clr,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [DATA_W-1:0] o_Read_Data,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // Counter reaches this value in the last permitted wait cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                access;
    logic                timeout_hit;
    logic                stall_c;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        stall_c     = 1'b0;
        access      = i_MEMRead_M | i_MEMWrite_M;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    addr_d  = i_ALU_out;
                    wdata_d = i_Data_Write;
                    we_d    = i_MEMWrite_M;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (i_mem_ack) begin
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    rdata_d     = '0;
                    req_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Set has priority over clear.
        err_d = err_q;
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stall       = stall_c & ~rst;
    assign o_bubble      = stall_c & ~rst;
    assign o_mem_req     = req_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_Read_Data   = rdata_q;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized accesses,
// checked against a transaction-level model of the MEM-stage handshake.
module tb_mem_stage_ctrl;

    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_MEMRead_M, i_MEMWrite_M;
    logic [DW-1:0] i_ALU_out, i_Data_Write, i_mem_rdata;
    logic          i_mem_ack, i_err_clr;
    logic          o_mem_req, o_mem_we, o_stall, o_bubble, o_timeout_err;
    logic [DW-1:0] o_mem_addr, o_mem_wdata, o_Read_Data;

    mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_MEMRead_M   (i_MEMRead_M),
        .i_MEMWrite_M  (i_MEMWrite_M),
        .i_ALU_out     (i_ALU_out),
        .i_Data_Write  (i_Data_Write),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .i_err_clr     (i_err_clr),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_Read_Data   (o_Read_Data),
        .o_stall       (o_stall),
        .o_bubble      (o_bubble),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural view of the stage as seen at its outputs.
    logic          m_we;
    logic [DW-1:0] m_addr, m_wdata, m_rd;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit s, input bit r);
        chk({tag, ".stall"},  {31'd0, o_stall},       {31'd0, s});
        chk({tag, ".bubble"}, {31'd0, o_bubble},      {31'd0, s});
        chk({tag, ".req"},    {31'd0, o_mem_req},     {31'd0, r});
        chk({tag, ".we"},     {31'd0, o_mem_we},      {31'd0, m_we});
        chk({tag, ".addr"},   {16'd0, o_mem_addr},    {16'd0, m_addr});
        chk({tag, ".wdata"},  {16'd0, o_mem_wdata},   {16'd0, m_wdata});
        chk({tag, ".rdata"},  {16'd0, o_Read_Data},   {16'd0, m_rd});
        chk({tag, ".err"},    {31'd0, o_timeout_err}, {31'd0, m_err});
    endtask

    function automatic bit pick_clr(input int mode);
        return (mode == 2) || (mode == 1 && $urandom_range(3) == 0);
    endfunction

    // One complete access: IDLE request cycle, wait cycles, DONE cycle.
    // delay = wait cycle carrying the ack (1 = first); 0 or > TO = never acked.
    task automatic do_access(input string tag, input bit rd, input bit wr,
                             input logic [DW-1:0] a, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rdat, input int delay,
                             input int clr_mode);
        bit clr;
        bit ack;
        @(negedge clk);
        i_MEMRead_M  = rd;
        i_MEMWrite_M = wr;
        i_ALU_out    = a;
        i_Data_Write = wd;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = 16'($urandom);
        clr          = pick_clr(clr_mode);
        i_err_clr    = clr;
        #1 chk_all({tag, " idle"}, 1'b1, 1'b0);
        m_we    = wr;
        m_addr  = a;
        m_wdata = wd;
        if (clr) m_err = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            ack = (k == delay);
            @(negedge clk);
            i_mem_ack   = ack;
            i_mem_rdata = ack ? rdat : 16'($urandom);
            clr         = pick_clr(clr_mode);
            i_err_clr   = clr;
            #1 chk_all($sformatf("%s wait%0d", tag, k), 1'b1, 1'b1);
            if (ack) begin
                if (!wr) m_rd = rdat;
                if (clr) m_err = 1'b0;
                break;
            end else if (k == TO) begin
                m_rd  = '0;
                m_err = 1'b1;
            end else if (clr) begin
                m_err = 1'b0;
            end
        end
        @(negedge clk);
        i_mem_ack = 1'b0;
        clr       = pick_clr(clr_mode);
        i_err_clr = clr;
        #1 chk_all({tag, " done"}, 1'b0, 1'b0);
        if (clr) m_err = 1'b0;
    endtask

    task automatic idle_cycle(input string tag, input bit ack, input bit clr);
        @(negedge clk);
        i_MEMRead_M  = 1'b0;
        i_MEMWrite_M = 1'b0;
        i_ALU_out    = 16'($urandom);
        i_Data_Write = 16'($urandom);
        i_mem_ack    = ack;
        i_mem_rdata  = 16'($urandom);
        i_err_clr    = clr;
        #1 chk_all(tag, 1'b0, 1'b0);
        if (clr) m_err = 1'b0;
    endtask

    initial begin
        bit rr, ww;
        rst          = 1'b1;
        i_MEMRead_M  = 1'b1;   // stall must stay low while reset is held
        i_MEMWrite_M = 1'b0;
        i_ALU_out    = 16'h1111;
        i_Data_Write = 16'h2222;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;
        i_err_clr    = 1'b0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0; m_err = 1'b0;

        repeat (2) @(negedge clk);
        #1 chk_all("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        i_MEMRead_M = 1'b0;
        idle_cycle("post_reset", 1'b1, 1'b0);

        do_access("load40", 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1, 0);
        do_access("store10", 1'b0, 1'b1, 16'h0010, 16'h1234, 16'hDEAD, 5, 0);

        do_access("tmo", 1'b1, 1'b0, 16'h0050, 16'h0000, 16'h5555, 0, 0);
        idle_cycle("late1", 1'b0, 1'b0);
        idle_cycle("late2", 1'b0, 1'b0);
        idle_cycle("late_ack", 1'b1, 1'b0);
        idle_cycle("clr", 1'b0, 1'b1);
        idle_cycle("cleared", 1'b0, 1'b0);

        do_access("both", 1'b1, 1'b1, 16'h0020, 16'hABCD, 16'h7777, 2, 0);
        do_access("b2b_a", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0A0A, 1, 0);
        do_access("b2b_b", 1'b1, 1'b0, 16'h0102, 16'h0000, 16'hB0B0, 1, 0);
        do_access("ack_at_limit", 1'b1, 1'b0, 16'h0060, 16'h0000, 16'hC0DE, TO, 0);
        do_access("tmo_setclr", 1'b0, 1'b1, 16'h0064, 16'h4321, 16'h0000, 0, 2);
        idle_cycle("after_setclr", 1'b0, 1'b0);

        // Reset arriving while an access is outstanding.
        @(negedge clk);
        i_MEMRead_M = 1'b1; i_MEMWrite_M = 1'b0;
        i_ALU_out = 16'h0070; i_Data_Write = 16'h9999; i_mem_ack = 1'b0;
        #1 chk_all("rst_idle", 1'b1, 1'b0);
        m_we = 1'b0; m_addr = 16'h0070; m_wdata = 16'h9999;
        @(negedge clk);
        #1 chk_all("rst_wait1", 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all("rst_held", 1'b0, 1'b1);
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0; i_MEMRead_M = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 16'hFACE;
        #1 chk_all("rst_after", 1'b0, 1'b0);
        idle_cycle("rst_ack_ignored", 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++)
                idle_cycle($sformatf("rnd%0d gap", n), bit'($urandom_range(1)),
                           $urandom_range(3) == 0);
            rr = bit'($urandom_range(1));
            ww = rr ? bit'($urandom_range(1)) : 1'b1;
            do_access($sformatf("rnd%0d", n), rr, ww, 16'($urandom), 16'($urandom),
                      16'($urandom), int'($urandom_range(TO + 2)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage against a variable-latency data memory using a req/ack handshake.
- Sits between the EX/MEM pipeline register outputs and the MEM/WB register.
- Freezes the upstream pipeline with o_stall while an access is outstanding, and feeds bubbles into MEM/WB.
- Aborts hung accesses with a cycle-count timeout and flags them with a sticky error.

Parameters:
DATA_W, 16, data and address width (matches ALU result width)
TIMEOUT, 15, max cycles in WAIT without ack before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_MEMRead_M  in  1  MEM-stage load request
i_MEMWrite_M  in  1  MEM-stage store request
i_ALU_out  in  DATA_W  MEM-stage address
i_Data_Write  in  DATA_W  MEM-stage store data
i_mem_ack  in  1  memory completion strobe, 1 cycle
i_mem_rdata  in  DATA_W  memory read data, valid with ack
i_err_clr  in  1  clears o_timeout_err
o_mem_req  out  1  access request to memory
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  DATA_W  registered address
o_mem_wdata  out  DATA_W  registered write data
o_Read_Data  out  DATA_W  load result to MEM/WB
o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
o_bubble  out  1  MEM/WB loads NOP (control bits cleared)
o_timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE; o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_Read_Data, o_timeout_err and the timeout counter are all 0.
- While rst is high, o_stall and o_bubble are forced to 0.
- Reset mid-access drops o_mem_req at the next edge. An ack arriving after that is ignored.
- access = i_MEMRead_M | i_MEMWrite_M. If both are set, treat it as a write.
- o_stall = (state==IDLE & access) | (state==WAIT).
- o_bubble = o_stall.
- IDLE:
  - If access: latch addr, wdata, we; clear the counter; go to WAIT.
  - o_mem_req rises at this edge.
- WAIT:
  - o_mem_req=1. addr, we and wdata are held stable.
  - The counter increments each cycle.
  - On i_mem_ack: if read, register i_mem_rdata into o_Read_Data; if write, o_Read_Data is unchanged. Drop req and go to DONE.
  - If there is no ack and the counter reaches TIMEOUT-1 this cycle: drop req, set o_timeout_err, set o_Read_Data=0, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - o_stall=0, so the pipeline advances at this edge and o_Read_Data is captured by MEM/WB. Go to IDLE.
  - The next instruction is evaluated in IDLE on the following cycle.
- Latency: minimum 2 stall cycles (IDLE+WAIT with ack in the first WAIT cycle), then 1 DONE cycle. Back-to-back accesses therefore cost 3 cycles each.
- A non-memory instruction in IDLE produces no stall and no req; the pipeline flows at full rate.
- i_mem_ack while not in WAIT is ignored. Late acks after a timeout are ignored.
- o_timeout_err:
  - Sets on timeout and clears on i_err_clr.
  - Set and clear in the same cycle: set wins.
  - Cleared only by rst or i_err_clr.

Test Plan:
- Load, addr 0x0040, ack 1 cycle after req, rdata 0xBEEF -> stall high 2 cycles; req high 1 cycle with addr 0x0040 and we=0; o_Read_Data=0xBEEF in DONE; stall low in DONE.
- Store, addr 0x0010, data 0x1234, ack after 5 cycles -> req held 5 cycles with addr/wdata/we=1 stable; stall 6 cycles; o_Read_Data unchanged; no error.
- Read with no ack, TIMEOUT=15 -> req drops after 15 WAIT cycles; o_timeout_err=1; o_Read_Data=0; pipeline resumes. A late ack 3 cycles later has no effect. i_err_clr then clears the flag.
- Read and write both asserted, addr 0x0020 -> o_mem_we=1 on the request.
- Two consecutive loads, each acked immediately -> two separate req pulses; 3 cycles per access; bubbles on stall cycles only.
- rst asserted in WAIT -> next cycle: req=0, stall=0, state IDLE, all outputs 0. An ack arriving in the following cycle is ignored.
